write_back_unit: RTL and testbench
==================================

// Module: write_back_unit
// PURPOSE
//  Parametrised in-order write-back stage with DEPTH-entry retirement queue. Accepts
//  completed instructions from the memory stage (valid/ready); loads wait in the
//  queue for late, in-order data on a separate return channel. Retires oldest first,
//  drives GPR/FPR write port and committed next-PC to fetch and register files.
// PARAMETERS
//  ADDR_W      32  PC / branch-destination width
//  REG_W       32  register data width
//  RADDR_W     5   destination register index width
//  DEPTH       4   queue entries (power of 2, >=2)
//  PC_INC      1   sequential PC increment (word-addressed)
// PORTS
//  clk         in   1        clock
//  rst         in   1        synchronous reset, active-high
//  in_valid    in   1        memory stage presents an instruction
//  in_ready    out  1        queue can accept (count < DEPTH)
//  in_pc       in   ADDR_W   instruction PC
//  in_bd       in   ADDR_W   branch destination
//  in_be       in   1        branch taken
//  in_is_load  in   1        result comes from ld channel (LW/LWCZ/ININT/INFLT)
//  in_op_d     in   REG_W    ALU/FPU result (ignored for loads)
//  in_rd       in   RADDR_W  destination register
//  in_gpr      in   1        writes GPR
//  in_fpr      in   1        writes FPR
//  ld_valid    in   1        load data beat, oldest outstanding load
//  ld_data     in   REG_W    load data
//  wb_valid    out  1        one instruction retired this cycle
//  wb_next_pc  out  ADDR_W   in_be ? in_bd : in_pc+PC_INC of retired instruction
//  gpr_we      out  1        GPR write enable (wb_valid & gpr)
//  fpr_we      out  1        FPR write enable (wb_valid & fpr)
//  wb_rd       out  RADDR_W  write index
//  wb_data     out  REG_W    load data for loads, else op_d
//  count       out  clog2(DEPTH)+1  occupied entries
//  ld_err      out  1        sticky: ld_valid with no outstanding load
// BEHAVIOUR
//  - Reset: all outputs 0 except in_ready=1; head/tail/load ptrs 0; entries invalid;
//    ld_err cleared. Reset mid-operation discards all queued/pending entries.
//  - Enqueue on in_valid & in_ready at tail; in_ready depends only on count (no
//    same-cycle pop bypass): full queue refuses input even if retiring.
//  - Entry: pc,bd,be,is_load,data,rd,gpr,fpr,data_ok. data_ok=1 at enqueue if !is_load.
//  - Load pointer tracks oldest entry with is_load & !data_ok. ld_valid fills it and
//    sets data_ok. If ld_valid coincides with enqueue of a load and no older load
//    is pending, data lands directly in the new entry. No pending load -> beat
//    dropped, ld_err set until rst.
//  - Retire: head valid & data_ok -> pop at clock edge, outputs registered; wb_*
//    valid for exactly that one cycle, otherwise wb_valid/gpr_we/fpr_we=0, data hold.
//    Max one retire per cycle, strictly program order.
//  - Latency: non-load enqueued at edge N retires with wb_valid high cycle N+2 (head
//    idle). Load: wb_valid cycle after its ld_valid edge, or later if blocked.
//  - Enqueue and retire in same cycle: count unchanged; pointers wrap mod DEPTH.
//  - wb_next_pc: ADDR_W arithmetic, pc+PC_INC wraps to 0 past max. gpr&fpr both set
//    -> both enables assert (no arbitration). Branch with no dest: both we=0.
// TESTING
//  1 ALU: pc=0x10,be=0,op_d=0x1234,rd=3,gpr -> cycle N+2 wb_valid,gpr_we,rd=3,
//    data=0x1234,next_pc=0x11
//  2 Branch: pc=0x20,be=1,bd=0x40,no dest -> wb_valid,next_pc=0x40,gpr_we=fpr_we=0
//  3 Load(rd=5,fpr) then ALU(rd=6); ld_data=0xCAFE 5 cycles later -> load retires
//    first (fpr_we,data=0xCAFE), ALU next cycle; ALU never overtakes
//  4 Enqueue 4 loads -> count=4,in_ready=0; return 4 beats -> retire in order,
//    in_ready=1 after first pop
//  5 pc=0xFFFFFFFF,be=0 -> next_pc=0; stray ld_valid on empty queue -> ld_err=1,
//    queue unaffected
//  6 rst while 3 entries queued/1 load pending -> next cycle count=0,wb_valid=0,
//    in_ready=1; later ld_valid sets ld_err

Source files
------------

// File: rtl/write_back_unit_if.sv
// Memory-stage to write-back handshake, load-return channel and retirement outputs.
// master = producer side (memory stage / bench), slave = write-back unit.
interface write_back_if #(
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 32,
    parameter int RADDR_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [ADDR_W-1:0]  in_pc;
    logic [ADDR_W-1:0]  in_bd;
    logic               in_be;
    logic               in_is_load;
    logic [REG_W-1:0]   in_op_d;
    logic [RADDR_W-1:0] in_rd;
    logic               in_gpr;
    logic               in_fpr;
    logic               ld_valid;
    logic [REG_W-1:0]   ld_data;
    logic               wb_valid;
    logic [ADDR_W-1:0]  wb_next_pc;
    logic               gpr_we;
    logic               fpr_we;
    logic [RADDR_W-1:0] wb_rd;
    logic [REG_W-1:0]   wb_data;

    modport master (
        output in_valid, in_pc, in_bd, in_be, in_is_load, in_op_d, in_rd, in_gpr, in_fpr,
        output ld_valid, ld_data,
        input  in_ready, wb_valid, wb_next_pc, gpr_we, fpr_we, wb_rd, wb_data
    );

    modport slave (
        input  in_valid, in_pc, in_bd, in_be, in_is_load, in_op_d, in_rd, in_gpr, in_fpr,
        input  ld_valid, ld_data,
        output in_ready, wb_valid, wb_next_pc, gpr_we, fpr_we, wb_rd, wb_data
    );
endinterface

// File: rtl/write_back_unit.sv
// In-order write-back stage: DEPTH-entry retirement queue, loads wait for in-order
// return data, one registered retirement per cycle driving register-file writes and next-PC.
module write_back_unit #(
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 4,
    parameter int PC_INC  = 1,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    write_back_if.slave      bus,
    output logic [CNT_W-1:0] count,
    output logic             ld_err
);
    logic [ADDR_W-1:0]  pc_mem   [DEPTH];
    logic [ADDR_W-1:0]  bd_mem   [DEPTH];
    logic [REG_W-1:0]   data_mem [DEPTH];
    logic [RADDR_W-1:0] rd_mem   [DEPTH];
    logic [DEPTH-1:0]   valid_reg, ok_reg, load_reg, be_reg, gpr_reg, fpr_reg;
    logic [PTR_W-1:0]   head_reg, tail_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               ld_err_reg;

    logic               wb_valid_reg, gpr_we_reg, fpr_we_reg;
    logic [ADDR_W-1:0]  wb_next_pc_reg;
    logic [RADDR_W-1:0] wb_rd_reg;
    logic [REG_W-1:0]   wb_data_reg;

    logic [DEPTH-1:0]   pend_vec;
    logic               pend_found;
    logic [PTR_W-1:0]   pend_idx;
    logic               in_ready, enq, pop, ld_fill, ld_direct, ld_stray;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pend
            assign pend_vec[gi] = valid_reg[gi] & load_reg[gi] & ~ok_reg[gi];
        end
    endgenerate

    // Oldest load still waiting for data, searched from the head in program order
    always_comb begin
        logic [PTR_W-1:0] idx;
        pend_found = 1'b0;
        pend_idx   = head_reg;
        idx        = head_reg;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_reg + PTR_W'(k);
            if (!pend_found && pend_vec[idx]) begin
                pend_found = 1'b1;
                pend_idx   = idx;
            end
        end
    end

    assign in_ready  = (count_reg < CNT_W'(DEPTH));
    assign enq       = bus.in_valid & in_ready;
    assign pop       = valid_reg[head_reg] & ok_reg[head_reg];
    assign ld_fill   = bus.ld_valid & pend_found;
    assign ld_direct = bus.ld_valid & ~pend_found & enq & bus.in_is_load;
    assign ld_stray  = bus.ld_valid & ~pend_found & ~(enq & bus.in_is_load);

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            valid_reg      <= '0;
            ok_reg         <= '0;
            ld_err_reg     <= 1'b0;
            wb_valid_reg   <= 1'b0;
            gpr_we_reg     <= 1'b0;
            fpr_we_reg     <= 1'b0;
            wb_next_pc_reg <= '0;
            wb_rd_reg      <= '0;
            wb_data_reg    <= '0;
        end else begin
            wb_valid_reg <= pop;
            gpr_we_reg   <= pop & gpr_reg[head_reg];
            fpr_we_reg   <= pop & fpr_reg[head_reg];
            if (pop) begin
                wb_rd_reg           <= rd_mem[head_reg];
                wb_data_reg         <= data_mem[head_reg];
                wb_next_pc_reg      <= be_reg[head_reg] ? bd_mem[head_reg]
                                                        : pc_mem[head_reg] + ADDR_W'(PC_INC);
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PTR_W'(1);
            end
            if (ld_fill) begin
                data_mem[pend_idx] <= bus.ld_data;
                ok_reg[pend_idx]   <= 1'b1;
            end
            if (enq) begin
                pc_mem[tail_reg]    <= bus.in_pc;
                bd_mem[tail_reg]    <= bus.in_bd;
                rd_mem[tail_reg]    <= bus.in_rd;
                data_mem[tail_reg]  <= ld_direct ? bus.ld_data : bus.in_op_d;
                be_reg[tail_reg]    <= bus.in_be;
                load_reg[tail_reg]  <= bus.in_is_load;
                gpr_reg[tail_reg]   <= bus.in_gpr;
                fpr_reg[tail_reg]   <= bus.in_fpr;
                ok_reg[tail_reg]    <= ~bus.in_is_load | ld_direct;
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + PTR_W'(1);
            end
            if (enq && !pop)
                count_reg <= count_reg + CNT_W'(1);
            else if (!enq && pop)
                count_reg <= count_reg - CNT_W'(1);
            if (ld_stray)
                ld_err_reg <= 1'b1;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.wb_valid   = wb_valid_reg;
    assign bus.gpr_we     = gpr_we_reg;
    assign bus.fpr_we     = fpr_we_reg;
    assign bus.wb_next_pc = wb_next_pc_reg;
    assign bus.wb_rd      = wb_rd_reg;
    assign bus.wb_data    = wb_data_reg;
    assign count          = count_reg;
    assign ld_err         = ld_err_reg;
endmodule

// File: tb/tb_write_back_unit.sv
// Directed bench for write_back_unit: queue-level reference model compared every cycle,
// plus literal expectations for each scenario.
module tb_write_back_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] count;
    logic       ld_err;

    write_back_if #(.ADDR_W(32), .REG_W(32), .RADDR_W(5)) bus ();

    write_back_unit #(.ADDR_W(32), .REG_W(32), .RADDR_W(5), .DEPTH(4), .PC_INC(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .count  (count),
        .ld_err (ld_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a plain queue of instructions in program order
    typedef struct {
        logic [31:0] pc, bd, data;
        logic        be, is_load, gpr, fpr, ok;
        logic [4:0]  rd;
    } ent_t;
    ent_t q[$];

    logic        m_wb_valid = 0, m_gpr = 0, m_fpr = 0, m_err = 0;
    logic [4:0]  m_rd = 0;
    logic [31:0] m_data = 0, m_npc = 0;

    task automatic model_step();
        bit   acc, pop, direct, found;
        ent_t e;
        if (rst) begin
            q.delete();
            m_wb_valid = 0; m_gpr = 0; m_fpr = 0; m_err = 0;
            m_rd = 0; m_data = 0; m_npc = 0;
            return;
        end
        acc = bus.in_valid && (q.size() < 4);
        pop = (q.size() > 0) && q[0].ok;
        m_wb_valid = pop;
        m_gpr = pop && q[0].gpr;
        m_fpr = pop && q[0].fpr;
        if (pop) begin
            m_rd   = q[0].rd;
            m_data = q[0].data;
            m_npc  = q[0].be ? q[0].bd : q[0].pc + 32'd1;
        end
        direct = 0;
        if (bus.ld_valid) begin
            found = 0;
            foreach (q[i])
                if (!found && q[i].is_load && !q[i].ok) begin
                    q[i].data = bus.ld_data;
                    q[i].ok   = 1;
                    found     = 1;
                end
            if (!found) begin
                if (acc && bus.in_is_load) direct = 1;
                else m_err = 1;
            end
        end
        if (pop) void'(q.pop_front());
        if (acc) begin
            e.pc = bus.in_pc; e.bd = bus.in_bd; e.be = bus.in_be;
            e.is_load = bus.in_is_load; e.rd = bus.in_rd;
            e.gpr = bus.in_gpr; e.fpr = bus.in_fpr;
            e.ok   = !bus.in_is_load || direct;
            e.data = bus.in_is_load ? (direct ? bus.ld_data : 32'd0) : bus.in_op_d;
            q.push_back(e);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("wb_valid", {31'd0, bus.wb_valid}, {31'd0, m_wb_valid});
            chk("gpr_we", {31'd0, bus.gpr_we}, {31'd0, m_gpr});
            chk("fpr_we", {31'd0, bus.fpr_we}, {31'd0, m_fpr});
            chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, m_rd});
            chk("wb_data", bus.wb_data, m_data);
            chk("wb_next_pc", bus.wb_next_pc, m_npc);
            chk("count", {29'd0, count}, q.size());
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (q.size() < 4)});
            chk("ld_err", {31'd0, ld_err}, {31'd0, m_err});
        end
    end

    // Retirement log, one line per retired instruction
    typedef struct {
        int          c;
        logic [4:0]  rd;
        logic [31:0] data, npc;
        logic        g, f;
    } log_t;
    log_t wlog[$];

    initial forever begin
        log_t l;
        @(negedge clk);
        if (bus.wb_valid === 1'b1) begin
            l.c = cyc; l.rd = bus.wb_rd; l.data = bus.wb_data; l.npc = bus.wb_next_pc;
            l.g = bus.gpr_we; l.f = bus.fpr_we;
            wlog.push_back(l);
            $display("retire cyc=%0d rd=%0d data=%h next_pc=%h gpr_we=%b fpr_we=%b",
                     cyc, bus.wb_rd, bus.wb_data, bus.wb_next_pc, bus.gpr_we, bus.fpr_we);
        end
    end

    // All driver tasks start and end 2 time units after a rising edge
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic set_in(input logic [31:0] pc, input logic [31:0] bd, input logic be,
                          input logic ld, input logic [31:0] op, input logic [4:0] rd,
                          input logic g, input logic f);
        bus.in_valid = 1; bus.in_pc = pc; bus.in_bd = bd; bus.in_be = be;
        bus.in_is_load = ld; bus.in_op_d = op; bus.in_rd = rd; bus.in_gpr = g; bus.in_fpr = f;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] bd, input logic be,
                        input logic ld, input logic [31:0] op, input logic [4:0] rd,
                        input logic g, input logic f);
        set_in(pc, bd, be, ld, op, rd, g, f);
        @(posedge clk); #2;
        bus.in_valid = 0;
    endtask

    task automatic ld_beat(input logic [31:0] d);
        bus.ld_valid = 1; bus.ld_data = d;
        @(posedge clk); #2;
        bus.ld_valid = 0;
    endtask

    initial begin
        bus.in_valid = 0; bus.in_pc = 0; bus.in_bd = 0; bus.in_be = 0; bus.in_is_load = 0;
        bus.in_op_d = 0; bus.in_rd = 0; bus.in_gpr = 0; bus.in_fpr = 0;
        bus.ld_valid = 0; bus.ld_data = 0;
        rst = 1;
        @(posedge clk); #2;
        chk_en = 1;
        idle(2);
        rst = 0;
        chk("rst count", {29'd0, count}, 32'd0);
        chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst ld_err", {31'd0, ld_err}, 32'd0);
        chk("rst wb_data", bus.wb_data, 32'd0);
        idle(1);

        // 1: ALU result, fixed latency
        push(32'h10, 32'h0, 0, 0, 32'h1234, 5'd3, 1, 0);
        @(negedge clk);
        chk("t1 early", {31'd0, bus.wb_valid}, 32'd0);
        chk("t1 count", {29'd0, count}, 32'd1);
        @(negedge clk);
        chk("t1 wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("t1 gpr_we", {31'd0, bus.gpr_we}, 32'd1);
        chk("t1 rd", {27'd0, bus.wb_rd}, 32'd3);
        chk("t1 data", bus.wb_data, 32'h1234);
        chk("t1 next_pc", bus.wb_next_pc, 32'h11);
        @(posedge clk); #2;
        idle(1);

        // 2: taken branch, no destination
        wlog.delete();
        push(32'h20, 32'h40, 1, 0, 32'h0, 5'd0, 0, 0);
        idle(3);
        chk("t2 n", wlog.size(), 32'd1);
        if (wlog.size() == 1) begin
            chk("t2 next_pc", wlog[0].npc, 32'h40);
            chk("t2 we", {30'd0, wlog[0].g, wlog[0].f}, 32'd0);
        end

        // 3: pending load blocks a younger ALU op
        wlog.delete();
        push(32'h30, 32'h0, 0, 1, 32'h0, 5'd5, 0, 1);
        push(32'h31, 32'h0, 0, 0, 32'h77, 5'd6, 1, 0);
        idle(4);
        chk("t3 blocked", wlog.size(), 32'd0);
        ld_beat(32'hCAFE);
        idle(3);
        chk("t3 n", wlog.size(), 32'd2);
        if (wlog.size() == 2) begin
            chk("t3 ld rd", {27'd0, wlog[0].rd}, 32'd5);
            chk("t3 ld data", wlog[0].data, 32'hCAFE);
            chk("t3 ld we", {30'd0, wlog[0].g, wlog[0].f}, 32'd1);
            chk("t3 alu rd", {27'd0, wlog[1].rd}, 32'd6);
            chk("t3 alu data", wlog[1].data, 32'h77);
            chk("t3 back2back", wlog[1].c - wlog[0].c, 32'd1);
        end

        // 4: fill queue with loads, full refuses input, in-order return
        wlog.delete();
        for (int i = 0; i < 4; i++)
            push(32'h100 + i, 32'h0, 0, 1, 32'h0, 5'(8 + i), 1, 0);
        chk("t4 count", {29'd0, count}, 32'd4);
        chk("t4 in_ready", {31'd0, bus.in_ready}, 32'd0);
        push(32'h200, 32'h0, 0, 0, 32'hDEAD, 5'd31, 1, 0);
        chk("t4 refused", {29'd0, count}, 32'd4);
        ld_beat(32'hA0);
        @(negedge clk);
        chk("t4 still full", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        chk("t4 first pop", {31'd0, bus.wb_valid}, 32'd1);
        chk("t4 ready after pop", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #2;
        for (int i = 1; i < 4; i++) ld_beat(32'hA0 + i);
        idle(3);
        chk("t4 n", wlog.size(), 32'd4);
        foreach (wlog[i]) begin
            chk("t4 order rd", {27'd0, wlog[i].rd}, 8 + i);
            chk("t4 order data", wlog[i].data, 32'hA0 + i);
        end

        // 7: back-to-back stream, simultaneous enqueue/retire, both register files
        wlog.delete();
        for (int i = 0; i < 6; i++) begin
            push(32'h300 + i, 32'h0, 0, 0, 32'h11 * i, 5'(20 + i), 1, 1);
            if (i == 3) chk("t7 steady count", {29'd0, count}, 32'd1);
        end
        idle(3);
        chk("t7 n", wlog.size(), 32'd6);
        foreach (wlog[i]) begin
            chk("t7 data", wlog[i].data, 32'h11 * i);
            chk("t7 both we", {30'd0, wlog[i].g, wlog[i].f}, 32'd3);
        end

        // 8: load data arrives together with the load's enqueue
        wlog.delete();
        set_in(32'h400, 32'h0, 0, 1, 32'h0, 5'd2, 1, 0);
        bus.ld_valid = 1; bus.ld_data = 32'hBEEF;
        @(posedge clk); #2;
        bus.in_valid = 0; bus.ld_valid = 0;
        idle(2);
        chk("t8 n", wlog.size(), 32'd1);
        if (wlog.size() == 1) chk("t8 data", wlog[0].data, 32'hBEEF);
        chk("t8 no err", {31'd0, ld_err}, 32'd0);

        // 5: next-PC wrap, stray load beat
        wlog.delete();
        push(32'hFFFF_FFFF, 32'h0, 0, 0, 32'h5, 5'd1, 1, 0);
        idle(3);
        chk("t5 n", wlog.size(), 32'd1);
        if (wlog.size() == 1) chk("t5 wrap", wlog[0].npc, 32'h0);
        ld_beat(32'h99);
        idle(2);
        chk("t5 ld_err", {31'd0, ld_err}, 32'd1);
        chk("t5 count", {29'd0, count}, 32'd0);
        chk("t5 no retire", wlog.size(), 32'd1);

        // 6: reset with entries queued and a load pending
        push(32'h500, 32'h0, 0, 1, 32'h0, 5'd4, 1, 0);
        push(32'h501, 32'h0, 0, 0, 32'h1, 5'd7, 1, 0);
        push(32'h502, 32'h0, 0, 0, 32'h2, 5'd9, 1, 0);
        chk("t6 count", {29'd0, count}, 32'd3);
        rst = 1;
        @(posedge clk); #2;
        rst = 0;
        chk("t6 count", {29'd0, count}, 32'd0);
        chk("t6 wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("t6 in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t6 ld_err clr", {31'd0, ld_err}, 32'd0);
        ld_beat(32'h55);
        idle(1);
        chk("t6 ld_err", {31'd0, ld_err}, 32'd1);
        chk("t6 still empty", {29'd0, count}, 32'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
